imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes a Y86-64 program image into the instruction memory's byte write port. It parses a framed stream with address, length, payload and checksum, and issues one byte write per accepted payload byte. It holds the pipeline in reset until an image has loaded cleanly. It sits between the host/testbench byte source and the instruction memory, as the writer counterpart of the fetch-side read port.

## Interface

- MEM_BYTES, 1024: instruction memory size in bytes. The valid write range is 0..MEM_BYTES-1.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse that opens a load session. Honoured only in IDLE, DONE or ERR.
- byte_valid_i  in  1  the source presents a byte.
- byte_data_i  in  8  stream byte.
- byte_ready_o  out  1  the loader accepts a byte. A transfer happens only when valid and ready are both high.
- wen_o  out  1  instruction memory byte write enable, one cycle per byte.
- waddr_o  out  64  write byte address, the same width as the fetch read address.
- wdata_o  out  8  write byte.
- busy_o  out  1  a session is in progress (header, data or checksum).
- done_o  out  1  sticky: the last session completed with a good checksum.
- err_o  out  2  sticky error code: 00 none, 01 range, 10 checksum.
- cpu_hold_o  out  1  holds the CPU in reset. Deasserts only on a good load.

## Operation

- Frame: BASE[7:0], BASE[15:8], LEN[7:0], LEN[15:8], then LEN payload bytes, then CSUM. All multi-byte fields are little-endian.
- CSUM is the 8-bit modular sum of the payload bytes.
- States:
  - IDLE: start_i → HDR.
  - HDR: counts 4 accepted bytes. After the 4th:
    - BASE+LEN > MEM_BYTES → ERR with err_o=01.
    - else LEN==0 → CSUM.
    - else → DATA.
  - DATA: accepts LEN bytes, then → CSUM.
  - CSUM: accepts 1 byte.
    - Match → DONE.
    - Mismatch → ERR with err_o=10.
  - DONE, ERR: start_i → HDR.
- Range arithmetic: BASE+LEN is computed at 17 bits, so there is no wrap. BASE+LEN == MEM_BYTES is legal.
- Write address: the payload byte with index k (from 0) writes waddr_o = BASE+k, zero-extended to 64 bits.
- The running sum is 8 bits and wraps mod 256. It clears on every entry to HDR.
- byte_ready_o is 1 in HDR, DATA and CSUM, and 0 in IDLE, DONE and ERR.
- start_i while busy_o=1 is ignored. Bytes presented while ready=0 are not consumed.
- A checksum error does not undo writes already issued. The memory holds the partial or corrupt image, and cpu_hold_o stays 1.
- A range error issues no writes.
- Entering HDR (on start) clears done_o and err_o, and sets cpu_hold_o=1.

## Timing

- Reset values:
  - state IDLE.
  - byte_ready_o=0, wen_o=0, waddr_o=0, wdata_o=0.
  - busy_o=0, done_o=0, err_o=00.
  - cpu_hold_o=1.
- start_i sampled at edge t → state HDR and byte_ready_o=1 from cycle t+1.
- Throughput is one byte per cycle with continuous valid. Arbitrary valid gaps are legal.
- Write latency: a payload byte accepted in cycle t → wen_o=1 with its address and data in cycle t+1 only.
- wen_o is a single-cycle pulse per byte. waddr_o and wdata_o hold their last value when wen_o=0.
- CSUM byte accepted in cycle t → in cycle t+1:
  - done_o=1, cpu_hold_o=0 and busy_o=0 together, or
  - err_o=10.
- The last payload write (cycle t) precedes done_o (cycle t+1).
- 4th header byte accepted in cycle t with a range fault → err_o=01, busy_o=0 and byte_ready_o=0 in cycle t+1.
- rst_i asserted mid-session:
  - At the next edge, all outputs take their reset values.
  - A pending write registered in the same cycle is dropped.
  - No further writes occur.
  - Memory contents are not cleared.

## Test plan

1. Good load: stream 00 00 03 00 30 F1 01 22, continuous valid.
   - Expect wen pulses writing addr 0/1/2 with 30/F1/01.
   - Expect done_o=1, err_o=00 and cpu_hold_o=0 one cycle after the 0x22 byte.
2. Range fault: BASE=0x03F8 (1016), LEN=0x0010.
   - Expect err_o=01 the cycle after the 4th byte.
   - Expect no wen_o and byte_ready_o=0.
   - Edge case BASE=1014, LEN=10 must succeed, with the last waddr_o=1023.
3. Checksum fault: frame 1 with CSUM=0x23.
   - Expect 3 writes, then err_o=10, done_o=0, cpu_hold_o=1.
   - A new start_i then clears err_o.
4. Backpressure and gaps: frame 1 with byte_valid_i toggling 1,0,0,1.
   - Expect exactly 3 writes, each 1 cycle after its accept, and the same final result.
   - start_i pulsed mid-DATA has no effect.
5. Reset mid-DATA: LEN=8, rst_i asserted after 3 payload accepts.
   - Expect exactly 3 writes (addr BASE..BASE+2).
   - Expect all outputs at reset values, and cpu_hold_o=1.
6. Empty image: stream 10 00 00 00 00.
   - Expect no wen_o, and done_o=1 the cycle after the CSUM byte.

Source files
------------

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the Y86-64 instruction memory write port.
// Parses BASE/LEN header, writes LEN payload bytes, verifies an 8-bit sum, and gates CPU reset.
module imem_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wen_o,
    output logic [63:0] waddr_o,
    output logic [7:0]  wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic        cpu_hold_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_BYTES);

    state_t      state_r;
    logic [1:0]  hdr_cnt_r;
    logic [15:0] base_r;
    logic [15:0] len_r;
    logic [15:0] addr_r;
    logic [15:0] rem_r;
    logic [7:0]  sum_r;
    logic        ready_r;
    logic        wen_r;
    logic [63:0] waddr_r;
    logic [7:0]  wdata_r;
    logic        busy_r;
    logic        done_r;
    logic [1:0]  err_r;
    logic        hold_r;

    logic        accept_s;
    logic [15:0] len_full_s;
    logic [16:0] range_end_s;

    // Handshake and header-completion arithmetic (17-bit end address so it never wraps).
    always_comb begin
        accept_s    = 1'b0;
        len_full_s  = 16'd0;
        range_end_s = 17'd0;
        if (byte_valid_i && ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        len_full_s  = {byte_data_i, len_r[7:0]};
        range_end_s = {1'b0, base_r} + {1'b0, len_full_s};
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            hdr_cnt_r <= 2'd0;
            base_r    <= 16'd0;
            len_r     <= 16'd0;
            addr_r    <= 16'd0;
            rem_r     <= 16'd0;
            sum_r     <= 8'd0;
            ready_r   <= 1'b0;
            wen_r     <= 1'b0;
            waddr_r   <= 64'd0;
            wdata_r   <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 2'b00;
            hold_r    <= 1'b1;
        end else begin
            wen_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_r   <= ST_HDR;
                        hdr_cnt_r <= 2'd0;
                        sum_r     <= 8'd0;
                        ready_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        err_r     <= 2'b00;
                        hold_r    <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        hdr_cnt_r <= hdr_cnt_r + 2'd1;
                        case (hdr_cnt_r)
                            2'd0: base_r[7:0]  <= byte_data_i;
                            2'd1: base_r[15:8] <= byte_data_i;
                            2'd2: len_r[7:0]   <= byte_data_i;
                            2'd3: begin
                                len_r  <= len_full_s;
                                addr_r <= base_r;
                                rem_r  <= len_full_s;
                                if (range_end_s > MEM_LIMIT) begin
                                    state_r <= ST_ERR;
                                    err_r   <= 2'b01;
                                    ready_r <= 1'b0;
                                    busy_r  <= 1'b0;
                                end else if (len_full_s == 16'd0) begin
                                    state_r <= ST_CSUM;
                                end else begin
                                    state_r <= ST_DATA;
                                end
                            end
                            default: hdr_cnt_r <= 2'd0;
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        wen_r   <= 1'b1;
                        waddr_r <= {48'd0, addr_r};
                        wdata_r <= byte_data_i;
                        sum_r   <= sum_r + byte_data_i;
                        addr_r  <= addr_r + 16'd1;
                        rem_r   <= rem_r - 16'd1;
                        if (rem_r == 16'd1) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        if (byte_data_i == sum_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            hold_r  <= 1'b0;
                        end else begin
                            state_r <= ST_ERR;
                            err_r   <= 2'b10;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = ready_r;
    assign wen_o        = wen_r;
    assign waddr_o      = waddr_r;
    assign wdata_o      = wdata_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign cpu_hold_o   = hold_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames driven byte by byte, writes captured and compared.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        wen_o;
    logic [63:0] waddr_o;
    logic [7:0]  wdata_o;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;
    logic        cpu_hold_o;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] wa[$];
    logic [7:0]  wd[$];
    logic        prev_acc = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    imem_loader #(.MEM_BYTES(1024)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .wen_o(wen_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .cpu_hold_o(cpu_hold_o)
    );

    always #5 clk_i = ~clk_i;

    // Capture writes and check each one follows an accept of the same byte one cycle earlier.
    always @(negedge clk_i) begin
        if (wen_o) begin
            wa.push_back(waddr_o);
            wd.push_back(wdata_o);
            nvec++;
            assert (prev_acc === 1'b1 && prev_data === wdata_o) else begin
                nerr++;
                $error("FAIL wen_latency: got acc=%0b data=%0h exp acc=1 data=%0h",
                       prev_acc, prev_data, wdata_o);
            end
        end
        prev_acc  = byte_valid_i && byte_ready_o && !rst_i;
        prev_data = byte_data_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            got = byte_ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_gap(input logic [7:0] b);
        byte_valid_i = 1'b0;
        tick(2);
        send(b);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic idle();
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
    endtask

    task automatic chk_frame1(input string tag);
        chk({tag, "_n"}, 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            chk({tag, "_a0"}, wa[0], 64'd0);
            chk({tag, "_d0"}, 64'(wd[0]), 64'h30);
            chk({tag, "_a1"}, wa[1], 64'd1);
            chk({tag, "_d1"}, 64'(wd[1]), 64'hF1);
            chk({tag, "_a2"}, wa[2], 64'd2);
            chk({tag, "_d2"}, 64'(wd[2]), 64'h01);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i = 8'h00;
        tick(2);
        chk("rst_ready", 64'(byte_ready_o), 64'd0);
        chk("rst_wen", 64'(wen_o), 64'd0);
        chk("rst_waddr", waddr_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_hold", 64'(cpu_hold_o), 64'd1);
        rst_i = 1'b0;
        tick(1);

        // 1: good load, continuous valid
        wa.delete(); wd.delete();
        pulse_start();
        chk("t1_ready", 64'(byte_ready_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        send(8'h00); send(8'h00); send(8'h03); send(8'h00);
        send(8'h30); send(8'hF1); send(8'h01);
        chk("t1_pre_done", 64'(done_o), 64'd0);
        send(8'h22);
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_err", 64'(err_o), 64'd0);
        chk("t1_hold", 64'(cpu_hold_o), 64'd0);
        chk("t1_busy_end", 64'(busy_o), 64'd0);
        chk("t1_ready_end", 64'(byte_ready_o), 64'd0);
        idle();
        chk_frame1("t1");

        // 2a: range fault 1016 + 16 > 1024
        wa.delete(); wd.delete();
        pulse_start();
        chk("t2_done_clr", 64'(done_o), 64'd0);
        chk("t2_hold_set", 64'(cpu_hold_o), 64'd1);
        send(8'hF8); send(8'h03); send(8'h10); send(8'h00);
        chk("t2_err", 64'(err_o), 64'd1);
        chk("t2_busy", 64'(busy_o), 64'd0);
        chk("t2_ready", 64'(byte_ready_o), 64'd0);
        idle();
        tick(3);
        chk("t2_nowrite", 64'(wa.size()), 64'd0);

        // 2b: edge 1014 + 10 == 1024 is legal
        pulse_start();
        chk("t2b_err_clr", 64'(err_o), 64'd0);
        send(8'hF6); send(8'h03); send(8'h0A); send(8'h00);
        for (int i = 1; i <= 10; i++) send(8'(i));
        send(8'h37);
        chk("t2b_done", 64'(done_o), 64'd1);
        chk("t2b_err", 64'(err_o), 64'd0);
        idle();
        chk("t2b_n", 64'(wa.size()), 64'd10);
        if (wa.size() == 10) begin
            chk("t2b_first_addr", wa[0], 64'd1014);
            chk("t2b_last_addr", wa[9], 64'd1023);
            chk("t2b_last_data", 64'(wd[9]), 64'h0A);
        end

        // 3: checksum fault
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h00); send(8'h00); send(8'h03); send(8'h00);
        send(8'h30); send(8'hF1); send(8'h01); send(8'h23);
        chk("t3_err", 64'(err_o), 64'd2);
        chk("t3_done", 64'(done_o), 64'd0);
        chk("t3_hold", 64'(cpu_hold_o), 64'd1);
        chk("t3_busy", 64'(busy_o), 64'd0);
        idle();
        chk_frame1("t3");
        pulse_start();
        chk("t3_err_clr", 64'(err_o), 64'd0);
        chk("t3_restart_busy", 64'(busy_o), 64'd1);

        // 4: gaps (valid 1,0,0,1) on the session opened above, start ignored mid-DATA
        wa.delete(); wd.delete();
        send_gap(8'h00); send_gap(8'h00); send_gap(8'h03); send_gap(8'h00);
        send_gap(8'h30);
        byte_valid_i = 1'b0;
        pulse_start();
        chk("t4_start_ignored_busy", 64'(busy_o), 64'd1);
        chk("t4_start_ignored_ready", 64'(byte_ready_o), 64'd1);
        send_gap(8'hF1); send_gap(8'h01); send_gap(8'h22);
        chk("t4_done", 64'(done_o), 64'd1);
        chk("t4_err", 64'(err_o), 64'd0);
        chk("t4_hold", 64'(cpu_hold_o), 64'd0);
        idle();
        chk_frame1("t4");

        // 5: reset mid-DATA after 3 payload accepts; 4th byte offered in the reset cycle
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h00); send(8'h01); send(8'h08); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC);
        rst_i = 1'b1;
        byte_valid_i = 1'b1;
        byte_data_i = 8'hDD;
        tick(1);
        chk("t5_ready", 64'(byte_ready_o), 64'd0);
        chk("t5_wen", 64'(wen_o), 64'd0);
        chk("t5_waddr", waddr_o, 64'd0);
        chk("t5_wdata", 64'(wdata_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_done", 64'(done_o), 64'd0);
        chk("t5_err", 64'(err_o), 64'd0);
        chk("t5_hold", 64'(cpu_hold_o), 64'd1);
        rst_i = 1'b0;
        idle();
        tick(3);
        chk("t5_n", 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            chk("t5_a0", wa[0], 64'h100);
            chk("t5_a2", wa[2], 64'h102);
            chk("t5_d2", 64'(wd[2]), 64'hCC);
        end

        // 6: empty image
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        chk("t6_pre_done", 64'(done_o), 64'd0);
        send(8'h00);
        chk("t6_done", 64'(done_o), 64'd1);
        chk("t6_hold", 64'(cpu_hold_o), 64'd0);
        chk("t6_err", 64'(err_o), 64'd0);
        idle();
        tick(2);
        chk("t6_nowrite", 64'(wa.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
